popcount_seq_ctrl: RTL and testbench



---
 rtl/popcount_seq_ctrl.sv | 121 ++++++++++++
 tb/tb_popcount_seq_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/popcount_seq_ctrl.sv
// Sequencer that streams a wide binary vector through one external 13-to-4 bit counter,
// one 13-bit slice per cycle, and accumulates the counts (saturating) across a vector group.
module popcount_seq_ctrl #(
    parameter int NSLICE = 9,
    parameter int ACC_W  = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [13*NSLICE-1:0]  in_data,
    input  logic                  in_last,
    output logic [12:0]           cnt_in,
    input  logic [3:0]            cnt_sum,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_W-1:0]      out_sum,
    output logic                  out_ovf,
    output logic                  busy
);

    localparam int VEC_W = 13 * NSLICE;
    localparam int IDX_W = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);
    localparam logic [ACC_W-1:0] ACC_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e               state_q, state_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic                 ovf_q, ovf_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [VEC_W-1:0]     shreg_q, shreg_d;
    logic                 last_q, last_d;
    logic [ACC_W:0]       sum_wide;

    // One spare bit on the adder: a carry into bit ACC_W means the group saturated.
    assign sum_wide = {1'b0, acc_q} + (ACC_W + 1)'(cnt_sum);

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        ovf_d     = ovf_q;
        idx_d     = idx_q;
        shreg_d   = shreg_q;
        last_d    = last_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_sum   = '0;
        out_ovf   = 1'b0;
        busy      = 1'b0;
        cnt_in    = '0;

        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    shreg_d = in_data;
                    last_d  = in_last;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                busy    = 1'b1;
                cnt_in  = shreg_q[12:0];
                if (sum_wide[ACC_W]) begin
                    acc_d = ACC_MAX;
                    ovf_d = 1'b1;
                end else begin
                    acc_d = sum_wide[ACC_W-1:0];
                end
                shreg_d = shreg_q >> 13;
                idx_d   = IDX_W'(idx_q + 1'b1);
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = last_q ? S_DONE : S_IDLE;
                end
            end

            S_DONE: begin
                out_valid = 1'b1;
                out_sum   = acc_q;
                out_ovf   = ovf_q;
                if (out_ready) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: the datapath shift register is cleared along with the control state, so a
    // reset mid-RUN leaves no stale slices behind for the next vector.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
            shreg_q <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_popcount_seq_ctrl.sv
// Self-checking bench for popcount_seq_ctrl: the external counter is a plain popcount and the
// reference is the group's total set-bit count, clipped to the accumulator range.
module tb_popcount_seq_ctrl;

    localparam int NSLICE  = 9;
    localparam int ACC_W   = 8;
    localparam int VW      = 13 * NSLICE;
    localparam int ACC_MAX = (1 << ACC_W) - 1;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              in_valid;
    logic              in_ready;
    logic [VW-1:0]     in_data;
    logic              in_last;
    logic [12:0]       cnt_in;
    logic [3:0]        cnt_sum;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic              out_ovf;
    logic              busy;

    int checks = 0;
    int errors = 0;
    int grp_total = 0;

    popcount_seq_ctrl #(.NSLICE(NSLICE), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .cnt_in    (cnt_in),
        .cnt_sum   (cnt_sum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // External 13-to-4 counter.
    assign cnt_sum = 4'($countones(cnt_in));

    function automatic logic [VW-1:0] ones_low(input int n);
        logic [VW-1:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [127:0] r;
        logic [127:0] m;
        r = {$urandom, $urandom, $urandom, $urandom};
        m = {$urandom, $urandom, $urandom, $urandom};
        case ($urandom_range(0, 3))
            0: r = '1;
            1: r = r & m;
            2: r = r | m;
            default: ;
        endcase
        return r[VW-1:0];
    endfunction

    task automatic do_reset();
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        grp_total = 0;
    endtask

    // Offer one vector, then follow it slice by slice through RUN.
    task automatic run_vector(input logic [VW-1:0] v, input bit last);
        int waited;
        waited   = 0;
        in_data  = v;
        in_last  = last;
        in_valid = 1'b1;
        while (!in_ready && waited < 30) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout: in_ready %b expected 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = rand_vec();
        in_last  = $urandom_range(0, 1);
        grp_total += $countones(v);
        for (int k = 0; k < NSLICE; k++) begin
            @(negedge clk);
            checks++;
            if (cnt_in !== v[13*k +: 13]) begin
                errors++;
                $display("FAIL cnt_in_slice%0d: got %h expected %h", k, cnt_in, v[13*k +: 13]);
            end
            checks++;
            if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL run_flags_slice%0d: busy %b in_ready %b out_valid %b expected 1 0 0",
                         k, busy, in_ready, out_valid);
            end
        end
        @(negedge clk);
        checks++;
        if (last) begin
            if (out_valid !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL done_entry: out_valid %b busy %b expected 1 0", out_valid, busy);
            end
        end else begin
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || cnt_in !== 13'h0) begin
                errors++;
                $display("FAIL chain_idle: out_valid %b in_ready %b busy %b cnt_in %h expected 0 1 0 0",
                         out_valid, in_ready, busy, cnt_in);
            end
        end
    endtask

    // Check the held result for stall+1 cycles, then consume it.
    task automatic take_result(input int stall, output int got_sum, output bit got_ovf);
        int waited;
        int exp_sum;
        bit exp_ovf;
        waited    = 0;
        out_ready = 1'b0;
        exp_sum   = (grp_total > ACC_MAX) ? ACC_MAX : grp_total;
        exp_ovf   = (grp_total > ACC_MAX);
        while (!out_valid && waited < 30) begin
            @(negedge clk);
            waited++;
        end
        got_sum = int'(out_sum);
        got_ovf = out_ovf;
        for (int s = 0; s <= stall; s++) begin
            checks++;
            if (out_valid !== 1'b1 || int'(out_sum) != exp_sum || out_ovf !== exp_ovf) begin
                errors++;
                $display("FAIL result_hold%0d: valid %b sum %0d ovf %b expected 1 %0d %b",
                         s, out_valid, out_sum, out_ovf, exp_sum, exp_ovf);
            end
            if (s < stall) @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        grp_total = 0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== '0 || out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL consume: valid %b in_ready %b sum %0d ovf %b expected 0 1 0 0",
                     out_valid, in_ready, out_sum, out_ovf);
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== '0 || out_ovf !== 1'b0 ||
            busy !== 1'b0 || cnt_in !== 13'h0) begin
            errors++;
            $display("FAIL reset_state: in_ready %b out_valid %b out_sum %0d out_ovf %b busy %b cnt_in %h",
                     in_ready, out_valid, out_sum, out_ovf, busy, cnt_in);
        end
    endtask

    task automatic test_single_vector();
        int s;
        bit o;
        run_vector('1, 1'b1);
        take_result(0, s, o);
        checks++;
        if (s != 117 || o !== 1'b0) begin
            errors++;
            $display("FAIL single_vector: sum %0d ovf %b expected 117 0", s, o);
        end
    endtask

    task automatic test_slice_routing();
        logic [VW-1:0] v;
        int s;
        bit o;
        v = '0;
        for (int k = 0; k < NSLICE; k++)
            for (int j = 0; j <= k; j++) v[13*k + j] = 1'b1;
        run_vector(v, 1'b1);
        take_result(0, s, o);
        checks++;
        if (s != 45 || o !== 1'b0) begin
            errors++;
            $display("FAIL slice_routing: sum %0d ovf %b expected 45 0", s, o);
        end
    endtask

    task automatic test_chain_backpressure();
        int s;
        bit o;
        run_vector(ones_low(40), 1'b0);
        run_vector(ones_low(20), 1'b1);
        take_result(5, s, o);
        checks++;
        if (s != 60 || o !== 1'b0) begin
            errors++;
            $display("FAIL chain_sum: sum %0d ovf %b expected 60 0", s, o);
        end
        run_vector(ones_low(3), 1'b1);
        take_result(0, s, o);
        checks++;
        if (s != 3) begin
            errors++;
            $display("FAIL chain_restart: sum %0d expected 3", s);
        end
    endtask

    task automatic test_saturation();
        int s;
        bit o;
        run_vector('1, 1'b0);
        run_vector('1, 1'b0);
        run_vector('1, 1'b1);
        take_result(2, s, o);
        checks++;
        if (s != 255 || o !== 1'b1) begin
            errors++;
            $display("FAIL saturation: sum %0d ovf %b expected 255 1", s, o);
        end
        run_vector(ones_low(5), 1'b1);
        take_result(0, s, o);
        checks++;
        if (s != 5 || o !== 1'b0) begin
            errors++;
            $display("FAIL post_saturation: sum %0d ovf %b expected 5 0", s, o);
        end
    endtask

    task automatic test_midrun_reset();
        int s;
        bit o;
        in_data  = '1;
        in_last  = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL midrun_busy: busy %b expected 1", busy);
        end
        reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        grp_total = 0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || cnt_in !== 13'h0) begin
            errors++;
            $display("FAIL midrun_reset: in_ready %b out_valid %b busy %b cnt_in %h expected 1 0 0 0",
                     in_ready, out_valid, busy, cnt_in);
        end
        run_vector(ones_low(7), 1'b1);
        take_result(0, s, o);
        checks++;
        if (s != 7 || o !== 1'b0) begin
            errors++;
            $display("FAIL midrun_fresh: sum %0d ovf %b expected 7 0", s, o);
        end
    endtask

    task automatic test_random();
        int s;
        bit o;
        int nvec;
        for (int g = 0; g < 12; g++) begin
            nvec = $urandom_range(1, 3);
            for (int n = 0; n < nvec; n++) begin
                out_ready = $urandom_range(0, 1);
                run_vector(rand_vec(), n == nvec - 1);
            end
            take_result($urandom_range(0, 3), s, o);
        end
    endtask

    initial begin
        test_reset();
        test_single_vector();
        test_slice_routing();
        test_chain_backpressure();
        test_saturation();
        test_midrun_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
